// File: rtl/time_set_12h.sv
// rtl/time_set_12h.sv - 12-hour time-set front end that loads edited time into the 24h time counter
module time_set_12h #(
    parameter int TIMEOUT_CYCLES = 1_000_000_000,
    parameter int TO_W           = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [26:0] cur_time,
    input  logic        set_req,
    input  logic        hour_inc,
    input  logic        min_inc,
    input  logic        ampm_toggle,
    input  logic        confirm,
    input  logic        cancel,
    output logic        editing,
    output logic [3:0]  set_hour12,
    output logic [5:0]  set_min,
    output logic        set_pm,
    output logic        time_wr_en,
    output logic [26:0] time_wr_data
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EDIT, S_COMMIT} state_t;

    state_t          state, next_state;
    logic [TO_W-1:0] to_cnt, to_cnt_d;
    logic [3:0]      hour_d;
    logic [5:0]      min_d;
    logic            pm_d;
    logic            editing_d;
    logic            wr_en_d;
    logic [26:0]     wr_data_d;
    logic [4:0]      cur_h24;
    logic [5:0]      cur_min;
    logic [4:0]      commit_h24;
    logic            any_pulse;
    logic            timed_out;
    logic            unused_cur;

    assign cur_h24    = cur_time[26:22];
    assign cur_min    = cur_time[21:16];
    assign unused_cur = ^cur_time[15:0];
    assign any_pulse  = set_req | hour_inc | min_inc | ampm_toggle | confirm | cancel;
    assign timed_out  = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // 12 AM maps to hour 0 and 12 PM stays 12; all other PM hours add 12.
    always_comb begin
        if (set_hour12 == 4'd12) begin
            commit_h24 = set_pm ? 5'd12 : 5'd0;
        end else begin
            commit_h24 = set_pm ? ({1'b0, set_hour12} + 5'd12) : {1'b0, set_hour12};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            to_cnt       <= '0;
            set_hour12   <= 4'd12;
            set_min      <= 6'd0;
            set_pm       <= 1'b0;
            editing      <= 1'b0;
            time_wr_en   <= 1'b0;
            time_wr_data <= 27'd0;
        end else begin
            state        <= next_state;
            to_cnt       <= to_cnt_d;
            set_hour12   <= hour_d;
            set_min      <= min_d;
            set_pm       <= pm_d;
            editing      <= editing_d;
            time_wr_en   <= wr_en_d;
            time_wr_data <= wr_data_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (set_req) next_state = S_LOAD;
            S_LOAD:   next_state = S_EDIT;
            S_EDIT: begin
                if (cancel) begin
                    next_state = S_IDLE;
                end else if (confirm) begin
                    next_state = S_COMMIT;
                end else if (!any_pulse && timed_out) begin
                    next_state = S_IDLE;
                end
            end
            S_COMMIT: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Flags are registered from the current state, so they trail the state by one cycle.
    always_comb begin
        hour_d    = set_hour12;
        min_d     = set_min;
        pm_d      = set_pm;
        to_cnt_d  = to_cnt;
        editing_d = (state == S_EDIT);
        wr_en_d   = (state == S_COMMIT);
        wr_data_d = time_wr_data;
        case (state)
            S_LOAD: begin
                to_cnt_d = '0;
                min_d    = (cur_min > 6'd59) ? 6'd0 : cur_min;
                if (cur_h24 == 5'd0 || cur_h24 > 5'd23) begin
                    hour_d = 4'd12;
                    pm_d   = 1'b0;
                end else if (cur_h24 < 5'd12) begin
                    hour_d = cur_h24[3:0];
                    pm_d   = 1'b0;
                end else if (cur_h24 == 5'd12) begin
                    hour_d = 4'd12;
                    pm_d   = 1'b1;
                end else begin
                    hour_d = 4'(cur_h24 - 5'd12);
                    pm_d   = 1'b1;
                end
            end
            S_EDIT: begin
                to_cnt_d = any_pulse ? '0 : to_cnt + 1'b1;
                if (!cancel && !confirm) begin
                    if (hour_inc)    hour_d = (set_hour12 == 4'd12) ? 4'd1 : set_hour12 + 4'd1;
                    if (min_inc)     min_d  = (set_min == 6'd59) ? 6'd0 : set_min + 6'd1;
                    if (ampm_toggle) pm_d   = ~set_pm;
                end
            end
            S_COMMIT: wr_data_d = {commit_h24, set_min, 16'd0};
            default: ;
        endcase
    end

endmodule

// File: tb/tb_time_set_12h.sv
// tb/tb_time_set_12h.sv - self-checking bench for time_set_12h
module tb_time_set_12h;
    localparam int T = 16;
    localparam int M_IDLE = 0, M_LOAD = 1, M_EDIT = 2, M_COMMIT = 3;
    localparam logic [5:0] P_SET = 6'b100000, P_HOUR = 6'b010000, P_MIN = 6'b001000,
                           P_AMPM = 6'b000100, P_CONF = 6'b000010, P_CANC = 6'b000001;
    localparam logic [39:0] RST_VAL = {1'b0, 4'd12, 6'd0, 1'b0, 1'b0, 27'd0};

    logic clk = 1'b0, rst_n = 1'b0;
    logic [26:0] cur_time = '0;
    logic set_req = 0, hour_inc = 0, min_inc = 0, ampm_toggle = 0, confirm = 0, cancel = 0;
    logic editing, set_pm, time_wr_en;
    logic [3:0] set_hour12;
    logic [5:0] set_min;
    logic [26:0] time_wr_data;

    time_set_12h #(.TIMEOUT_CYCLES(T), .TO_W(30)) dut (
        .clk(clk), .rst_n(rst_n), .cur_time(cur_time), .set_req(set_req), .hour_inc(hour_inc),
        .min_inc(min_inc), .ampm_toggle(ampm_toggle), .confirm(confirm), .cancel(cancel),
        .editing(editing), .set_hour12(set_hour12), .set_min(set_min), .set_pm(set_pm),
        .time_wr_en(time_wr_en), .time_wr_data(time_wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int m_mode, m_h24, m_min, m_cnt;
    logic e_editing, e_wr_en;
    logic [26:0] e_wr_data;

    typedef struct {int h_in; int m_in; int e_h12; int e_pm; int e_min; int e_wr_h;} vec_t;
    vec_t vt[8];

    function automatic logic [39:0] act_bus();
        return {editing, set_hour12, set_min, set_pm, time_wr_en, time_wr_data};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_h24 = 0; m_min = 0; m_cnt = 0;
        e_editing = 0; e_wr_en = 0; e_wr_data = '0;
    endtask

    // Edited time kept as a 24h hour; 12h fields are derived from it.
    task automatic model_step();
        logic any;
        any = set_req | hour_inc | min_inc | ampm_toggle | confirm | cancel;
        e_editing = (m_mode == M_EDIT);
        e_wr_en   = (m_mode == M_COMMIT);
        if (m_mode == M_COMMIT) e_wr_data = {5'(m_h24), 6'(m_min), 16'd0};
        case (m_mode)
            M_IDLE: if (set_req) m_mode = M_LOAD;
            M_LOAD: begin
                m_h24 = int'(cur_time[26:22]);
                if (m_h24 > 23) m_h24 = 0;
                m_min = int'(cur_time[21:16]);
                if (m_min > 59) m_min = 0;
                m_cnt = 0;
                m_mode = M_EDIT;
            end
            M_EDIT: begin
                if (cancel) m_mode = M_IDLE;
                else if (confirm) m_mode = M_COMMIT;
                else begin
                    if (hour_inc) m_h24 = (m_h24 / 12) * 12 + ((m_h24 % 12) + 1) % 12;
                    if (min_inc) m_min = (m_min + 1) % 60;
                    if (ampm_toggle) m_h24 = (m_h24 + 12) % 24;
                    if (any) m_cnt = 0;
                    else if (m_cnt == T - 1) m_mode = M_IDLE;
                    else m_cnt++;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endtask

    function automatic logic [39:0] exp_bus();
        int h12;
        h12 = (m_h24 % 12 == 0) ? 12 : m_h24 % 12;
        return {e_editing, 4'(h12), 6'(m_min), m_h24 >= 12, e_wr_en, e_wr_data};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("model", act_bus(), exp_bus());
    endtask

    task automatic drive(input logic [5:0] p);
        {set_req, hour_inc, min_inc, ampm_toggle, confirm, cancel} = p;
        tick();
        {set_req, hour_inc, min_inc, ampm_toggle, confirm, cancel} = '0;
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1 chk("reset_now", act_bus(), RST_VAL);
        model_reset();
        #2 rst_n = 1'b1;
    endtask

    task automatic enter_edit(input int h, input int m);
        cur_time = {5'(h), 6'(m), 16'hA5C3};
        drive(P_SET);
        drive(0);
        drive(0);
    endtask

    initial begin
        int cnt_ed, cnt_wr;
        model_reset();
        #12;
        chk("reset_state", act_bus(), RST_VAL);
        rst_n = 1'b1;

        vt[0] = '{0, 5, 12, 0, 5, 0};    vt[1] = '{23, 59, 11, 1, 59, 23};
        vt[2] = '{12, 30, 12, 1, 30, 12}; vt[3] = '{13, 0, 1, 1, 0, 13};
        vt[4] = '{11, 7, 11, 0, 7, 11};   vt[5] = '{27, 5, 12, 0, 5, 0};
        vt[6] = '{5, 63, 5, 0, 0, 5};     vt[7] = '{31, 60, 12, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            enter_edit(vt[i].h_in, vt[i].m_in);
            chk("load_fields", {editing, set_hour12, set_pm, set_min},
                {1'b1, 4'(vt[i].e_h12), 1'(vt[i].e_pm), 6'(vt[i].e_min)});
            drive(P_CONF);
            chk("no_early_strobe", {39'd0, time_wr_en}, 40'd0);
            drive(0);
            chk("commit", {12'd0, time_wr_en, time_wr_data},
                {12'd0, 1'b1, 5'(vt[i].e_wr_h), 6'(vt[i].e_min), 16'd0});
            drive(0);
            chk("strobe_one_cycle", {12'd0, time_wr_en, time_wr_data},
                {12'd0, 1'b0, 5'(vt[i].e_wr_h), 6'(vt[i].e_min), 16'd0});
        end

        enter_edit(11, 20);
        drive(P_HOUR);
        chk("hour_11_to_12am", {35'd0, set_hour12, set_pm}, {35'd0, 4'd12, 1'b0});
        drive(P_HOUR);
        chk("hour_12_to_1am", {35'd0, set_hour12, set_pm}, {35'd0, 4'd1, 1'b0});
        drive(P_AMPM);
        drive(P_CONF);
        drive(0);
        chk("pm1_commit", {28'd0, time_wr_en, time_wr_data[26:16]}, {28'd0, 1'b1, 5'd13, 6'd20});

        enter_edit(3, 10);
        drive(P_CONF | P_CANC);
        cnt_wr = 0;
        for (int i = 0; i < 3; i++) begin drive(0); cnt_wr += int'(time_wr_en); end
        chk("cancel_wins", {38'd0, editing, cnt_wr != 0}, 40'd0);
        enter_edit(3, 10);
        drive(P_HOUR | P_MIN | P_AMPM);
        chk("multi_edit", {29'd0, set_hour12, set_pm, set_min}, {29'd0, 4'd4, 1'b1, 6'd11});
        drive(P_SET);
        chk("set_req_in_edit", {29'd0, set_hour12, set_pm, set_min}, {29'd0, 4'd4, 1'b1, 6'd11});
        drive(P_CANC);

        enter_edit(8, 0);
        cnt_ed = 1; cnt_wr = 0;
        for (int i = 0; i < 24; i++) begin drive(0); cnt_ed += int'(editing); cnt_wr += int'(time_wr_en); end
        chk("timeout_len", 40'(cnt_ed), 40'(T));
        chk("timeout_no_wr", 40'(cnt_wr), 40'd0);

        cur_time = {5'd8, 6'd0, 16'd0};
        drive(P_SET);
        drive(0);
        cnt_ed = 0; cnt_wr = 0;
        for (int i = 0; i < 40; i++) begin
            drive(i == 10 ? P_MIN : 6'd0);
            cnt_ed += int'(editing); cnt_wr += int'(time_wr_en);
        end
        chk("timeout_restart", 40'(cnt_ed), 40'(T + 11));
        chk("restart_no_wr", 40'(cnt_wr), 40'd0);

        enter_edit(9, 9);
        drive(P_MIN);
        async_reset();
        cnt_wr = 0;
        for (int i = 0; i < 3; i++) begin drive(0); cnt_wr += int'(time_wr_en | editing); end
        chk("reset_mid_edit", 40'(cnt_wr), 40'd0);
        enter_edit(9, 9);
        drive(P_CONF);
        async_reset();
        cnt_wr = 0;
        for (int i = 0; i < 3; i++) begin drive(0); cnt_wr += int'(time_wr_en); end
        chk("reset_in_commit", 40'(cnt_wr), 40'd0);

        for (int i = 0; i < 3000; i++) begin
            cur_time = {5'($urandom_range(0, 31)), 6'($urandom_range(0, 63)), 16'($urandom)};
            set_req     = ($urandom_range(0, 5) == 0);
            hour_inc    = ($urandom_range(0, 7) == 0);
            min_inc     = ($urandom_range(0, 7) == 0);
            ampm_toggle = ($urandom_range(0, 9) == 0);
            confirm     = ($urandom_range(0, 19) == 0);
            cancel      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 3) == 0) {set_req, hour_inc, min_inc, ampm_toggle, confirm, cancel} = '0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
